// File: rtl/wash_timer_if.sv
// Controller <-> wash_timer link: the controller publishes its state code and
// consumes the countdowns, wash phase, completion flag and remaining run time.
interface wash_timer_if;
   logic [2:0] state;
   logic [2:0] initTime;
   logic [2:0] finishTime;
   logic [1:0] sleepTime;
   logic [2:0] shinning;
   logic       hadFinish;
   logic [7:0] remainTime;

   modport master (
      output state,
      input  initTime,
      input  finishTime,
      input  sleepTime,
      input  shinning,
      input  hadFinish,
      input  remainTime
   );

   modport slave (
      input  state,
      output initTime,
      output finishTime,
      output sleepTime,
      output shinning,
      output hadFinish,
      output remainTime
   );
endinterface

// File: rtl/wash_timer.sv
// Washer timing block: one-second tick from cp, begin/finish/sleep countdowns
// and the eight-phase wash program sequencer answering the state controller.
module wash_timer #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned INIT_S   = 5,
   parameter int unsigned FINISH_S = 6,
   parameter int unsigned SLEEP_S  = 3,
   parameter int unsigned FILL_S   = 2,
   parameter int unsigned WASH_S   = 5,
   parameter int unsigned SPIN_S   = 3,
   parameter int unsigned RINSE_S  = 4,
   parameter int unsigned DRAIN_S  = 2
) (
   input logic         cp,
   input logic         rst,
   wash_timer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_SHUTDOWN = 3'd0,
      ST_BEGIN    = 3'd1,
      ST_SET      = 3'd2,
      ST_RUN      = 3'd3,
      ST_ERROR    = 3'd4,
      ST_PAUSE    = 3'd5,
      ST_FINISH   = 3'd6,
      ST_SLEEP    = 3'd7
   } ctrl_state_e;

   typedef enum logic [2:0] {
      PH_IDLE       = 3'd0,
      PH_FILL       = 3'd1,
      PH_WASH       = 3'd2,
      PH_SPIN       = 3'd3,
      PH_REFILL     = 3'd4,
      PH_RINSE      = 3'd5,
      PH_DRAIN      = 3'd6,
      PH_FINAL_SPIN = 3'd7
   } phase_e;

   localparam int unsigned TOTAL     = 2*FILL_S + WASH_S + 2*SPIN_S + RINSE_S + DRAIN_S;
   localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);
   localparam logic [7:0]  TOTAL_8   = 8'(TOTAL);
   localparam logic [2:0]  INIT_3    = 3'(INIT_S);
   localparam logic [2:0]  FINISH_3  = 3'(FINISH_S);
   localparam logic [1:0]  SLEEP_2   = 2'(SLEEP_S);

   function automatic logic [3:0] phase_len(input phase_e p);
      logic [3:0] len;
      len = '0;
      case (p)
         PH_FILL, PH_REFILL:     len = 4'(FILL_S);
         PH_WASH:                len = 4'(WASH_S);
         PH_SPIN, PH_FINAL_SPIN: len = 4'(SPIN_S);
         PH_RINSE:               len = 4'(RINSE_S);
         PH_DRAIN:               len = 4'(DRAIN_S);
         default:                len = '0;
      endcase
      return len;
   endfunction

   ctrl_state_e state_in;
   logic        changed;
   logic        tick;
   logic [2:0]  phase_inc;

   ctrl_state_e prev_state_q, prev_state_d;
   logic [25:0] tick_cnt_q,   tick_cnt_d;
   logic [2:0]  init_time_q,  init_time_d;
   logic [2:0]  finish_time_q, finish_time_d;
   logic [1:0]  sleep_time_q, sleep_time_d;
   phase_e      shinning_q,   shinning_d;
   logic [3:0]  phase_cnt_q,  phase_cnt_d;
   logic        had_finish_q, had_finish_d;
   logic [7:0]  remain_time_q, remain_time_d;

   // Tick is withheld on a state-change edge so the in-progress second restarts.
   always_comb begin
      state_in     = ctrl_state_e'(bus.state);
      changed      = (state_in != prev_state_q);
      tick         = (tick_cnt_q == TICK_LAST) && !changed;
      prev_state_d = state_in;
      tick_cnt_d   = (changed || tick) ? '0 : tick_cnt_q + 26'd1;
   end

   always_comb begin
      init_time_d   = init_time_q;
      finish_time_d = finish_time_q;
      sleep_time_d  = sleep_time_q;

      if (state_in != ST_BEGIN)          init_time_d = INIT_3;
      else if (tick && init_time_q != '0) init_time_d = init_time_q - 3'd1;

      if (state_in != ST_FINISH)            finish_time_d = FINISH_3;
      else if (tick && finish_time_q != '0) finish_time_d = finish_time_q - 3'd1;

      if (state_in != ST_SLEEP)            sleep_time_d = SLEEP_2;
      else if (tick && sleep_time_q != '0) sleep_time_d = sleep_time_q - 2'd1;
   end

   // Program sequencer: shinning_q is the phase state, phase_cnt_q the seconds left in it.
   always_comb begin
      shinning_d    = shinning_q;
      phase_cnt_d   = phase_cnt_q;
      had_finish_d  = had_finish_q;
      remain_time_d = remain_time_q;
      phase_inc     = shinning_q + 3'd1;

      case (state_in)
         ST_SHUTDOWN, ST_BEGIN, ST_SET: begin
            shinning_d    = PH_IDLE;
            phase_cnt_d   = '0;
            had_finish_d  = 1'b0;
            remain_time_d = TOTAL_8;
         end
         ST_RUN: begin
            if (shinning_q == PH_IDLE && !had_finish_q) begin
               shinning_d    = PH_FILL;
               phase_cnt_d   = phase_len(PH_FILL);
               remain_time_d = TOTAL_8;
            end else if (shinning_q != PH_IDLE && tick) begin
               if (remain_time_q != '0) remain_time_d = remain_time_q - 8'd1;
               if (phase_cnt_q > 4'd1) begin
                  phase_cnt_d = phase_cnt_q - 4'd1;
               end else if (shinning_q != PH_FINAL_SPIN) begin
                  shinning_d  = phase_e'(phase_inc);
                  phase_cnt_d = phase_len(phase_e'(phase_inc));
               end else begin
                  shinning_d    = PH_IDLE;
                  phase_cnt_d   = '0;
                  remain_time_d = '0;
                  had_finish_d  = 1'b1;
               end
            end
         end
         ST_FINISH: begin
            shinning_d   = PH_IDLE;
            phase_cnt_d  = '0;
            had_finish_d = 1'b1;
         end
         ST_ERROR, ST_PAUSE, ST_SLEEP: begin
            shinning_d = shinning_q;
         end
         default: begin
            shinning_d = shinning_q;
         end
      endcase
   end

   always_ff @(posedge cp) begin
      if (rst) begin
         prev_state_q  <= ST_SHUTDOWN;
         tick_cnt_q    <= '0;
         init_time_q   <= INIT_3;
         finish_time_q <= FINISH_3;
         sleep_time_q  <= SLEEP_2;
         shinning_q    <= PH_IDLE;
         phase_cnt_q   <= '0;
         had_finish_q  <= 1'b0;
         remain_time_q <= TOTAL_8;
      end else begin
         prev_state_q  <= prev_state_d;
         tick_cnt_q    <= tick_cnt_d;
         init_time_q   <= init_time_d;
         finish_time_q <= finish_time_d;
         sleep_time_q  <= sleep_time_d;
         shinning_q    <= shinning_d;
         phase_cnt_q   <= phase_cnt_d;
         had_finish_q  <= had_finish_d;
         remain_time_q <= remain_time_d;
      end
   end

   assign bus.initTime   = init_time_q;
   assign bus.finishTime = finish_time_q;
   assign bus.sleepTime  = sleep_time_q;
   assign bus.shinning   = shinning_q;
   assign bus.hadFinish  = had_finish_q;
   assign bus.remainTime = remain_time_q;

endmodule

// File: doc/wash_timer.md
# wash_timer

Timing and wash-program sequencer that answers the washing-machine state controller. It samples the controller's 3-bit `state` code, divides `cp` down to a one-second tick, and returns every timing and progress input the controller consumes: `initTime`, `finishTime`, `sleepTime`, `shinning` (current wash phase) and `hadFinish`. It also drives `remainTime` for the seven-segment display.

## Interface
- `TICK_DIV`, 50_000_000: `cp` cycles per one-second tick; benches use 4.
- `INIT_S`, 5: power-on countdown (≤7).
- `FINISH_S`, 6: end-of-program countdown (≤7).
- `SLEEP_S`, 3: sleep countdown (≤3).
- `FILL_S`, 2; `WASH_S`, 5; `SPIN_S`, 3; `RINSE_S`, 4; `DRAIN_S`, 2: phase lengths in seconds, each 1..15.
- `cp` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `state` in 3: controller state. 0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish, 7 sleep.
- `initTime` out 3: begin countdown.
- `finishTime` out 3: finish countdown.
- `sleepTime` out 2: sleep countdown.
- `shinning` out 3: wash phase. 0 idle, 1 fill, 2 wash, 3 spin, 4 fill, 5 rinse, 6 drain, 7 final spin.
- `hadFinish` out 1: program complete.
- `remainTime` out 8: run seconds left.

## Operation
- TOTAL = 2·FILL_S + WASH_S + 2·SPIN_S + RINSE_S + DRAIN_S (default 21).
- Phase lengths: 1, 4 → FILL_S; 2 → WASH_S; 3, 7 → SPIN_S; 5 → RINSE_S; 6 → DRAIN_S.
- All outputs are registered. Internal registers:
  - `prevState`
  - `tickCnt`, 26 bits, sized for `TICK_DIV`
  - `phaseCnt`, 4 bits
- `changed` = (`state` ≠ `prevState`).
- `tick` = (`tickCnt` == TICK_DIV−1) && !`changed`.
- Tick counter:
  - Reset or `changed` → 0.
  - Otherwise it wraps at TICK_DIV−1.
  - The first tick in any new state comes exactly TICK_DIV cycles after entry.
- Countdowns:
  - `initTime`: reloads INIT_S whenever `state` ≠ 1. In state 1 it decrements on `tick` and saturates at 0.
  - `finishTime`: same behaviour, keyed on state 6 and FINISH_S.
  - `sleepTime`: same behaviour, keyed on state 7 and SLEEP_S.
- Program sequencer, by state:
  - States 0, 1, 2: `shinning`=0, `phaseCnt`=0, `hadFinish`=0, `remainTime`=TOTAL.
  - State 3 with `shinning`==0 and !`hadFinish`: next edge sets `shinning`=1, `phaseCnt`=FILL_S, `remainTime`=TOTAL. This is the start edge.
  - State 3 on `tick` with `shinning`≠0: `remainTime` decrements (saturating at 0).
  - If `phaseCnt`>1, `phaseCnt` decrements.
  - Otherwise, if `shinning`<7, `shinning` increments and `phaseCnt` loads the next phase's length.
  - Otherwise (`phaseCnt`≤1 in phase 7): `shinning`=0, `phaseCnt`=0, `remainTime`=0, `hadFinish`=1.
  - State 3 with `hadFinish`=1: everything holds, and the program does not restart.
  - States 4, 5, 7: phase, `phaseCnt`, `remainTime` and `hadFinish` hold, so the program resumes exactly where it stopped.
  - State 6: `hadFinish` held at 1; phase registers hold at 0.
- `state` is sampled only on `cp`. Illegal codes do not exist (3-bit, all decoded).

## Timing
- Reset values:
  - `initTime`=INIT_S, `finishTime`=FINISH_S, `sleepTime`=SLEEP_S
  - `shinning`=0, `hadFinish`=0, `remainTime`=TOTAL
  - `tickCnt`=0, `prevState`=0
- `rst` overrides everything in the same edge, including mid-run: `shinning` returns to 0 and `hadFinish` to 0.
- Latency:
  - Outputs change one edge after the causing `state` or `tick` condition.
  - `hadFinish` rises on the edge of the last tick of phase 7, i.e. TOTAL·TICK_DIV cycles after the start edge, if never interrupted.
- Interruption costs partial ticks. On return to state 3 the tick counter restarts, so the in-progress second is re-timed from zero.
- A state change and a would-be tick on the same edge: the tick is suppressed, and the countdown or phase is not advanced.
- Countdowns never wrap below 0, and `remainTime` never underflows.

## Test plan
All scenarios use TICK_DIV=4 and default parameters.
- **Reset:** hold `rst` 3 cycles → `initTime`=5, `finishTime`=6, `sleepTime`=3, `shinning`=0, `hadFinish`=0, `remainTime`=21.
- **Begin countdown:** `state`=1 for 24 cycles.
  - `initTime` steps 5→4 at cycle 4, reaches 0 at cycle 20, and stays 0.
  - Switching to `state`=2 reloads 5 next edge.
- **Full run:** `state`=2, then 3 held.
  - `shinning`=1 one edge after entry.
  - `shinning`=2 after 8 cycles, 3 after 28, 7 after 72.
  - `hadFinish`=1 and `shinning`=0 after 84 cycles; `remainTime` tracks 21→0.
- **Pause/resume:** in state 3, switch to 5 at `shinning`=2 with `remainTime`=17 for 40 cycles.
  - Everything holds.
  - Back to 3: `remainTime`=16 exactly 4 cycles later.
- **Sleep:** `state`=7 for 16 cycles → `sleepTime` 3,2,1,0 at cycles 4/8/12 and holds 0; phase frozen.
- **Finish, and reset mid-run:**
  - `state`=6 → `finishTime` reaches 0 after 24 cycles.
  - Assert `rst` during state 3 with `shinning`=5 → next edge `shinning`=0, `remainTime`=21.
